phys_free_list: RTL and testbench

//  Circular FIFO of free physical register tags. Feeds the rename table: one tag
//  per cycle on free_phy_addr, and takes back tags the rename/commit path retires.
//  8-page head-pointer checkpoints, in sync with the branch buffer's page numbers,
//  let a mispredicted branch reclaim every tag allocated after the branch.

---
 rtl/phys_free_list_if.sv | 27 ++
 rtl/phys_free_list.sv | 67 ++++++
 tb/tb_phys_free_list.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/phys_free_list_if.sv
// phys_free_list_if: allocation, release and checkpoint signals of the physical-register free list.
interface phys_free_list_if #(
    parameter int TAG_W = 8,
    parameter int AW    = 7
);
    logic             alloc_req;
    logic [TAG_W-1:0] free_phy_addr;
    logic             alloc_valid;
    logic             empty;
    logic             release_valid;
    logic [TAG_W-1:0] release_tag;
    logic             save_state;
    logic [2:0]       save_page;
    logic             restore_state;
    logic [2:0]       restore_page;
    logic [AW:0]      free_count;
    logic             overflow_err;

    modport master (
        output alloc_req, release_valid, release_tag, save_state, save_page, restore_state, restore_page,
        input  free_phy_addr, alloc_valid, empty, free_count, overflow_err
    );
    modport slave (
        input  alloc_req, release_valid, release_tag, save_state, save_page, restore_state, restore_page,
        output free_phy_addr, alloc_valid, empty, free_count, overflow_err
    );
endinterface

// File: rtl/phys_free_list.sv
// phys_free_list: circular FIFO of free physical tags with 8 head checkpoints for branch recovery.
// Define FREE_LIST_BYPASS_EN to forward a release straight to the allocator when the list is empty.
module phys_free_list #(
    parameter int DEPTH     = 128,
    parameter int FIRST_TAG = 32,
    parameter int TAG_W     = 8,
    parameter int AW        = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             reset,
    phys_free_list_if.slave fl
);
    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [AW:0]      ckpt_q [8];
    logic [AW:0]      head_q, head_d, head_nxt, tail_q, count;
    logic [TAG_W-1:0] addr_q;
    logic             valid_q, ovf_q;
    logic             zero, full, rel_ok, pop, byp, push, drop;

    always_comb begin
        count    = tail_q - head_q;
        zero     = count == '0;
        full     = count == (AW+1)'(DEPTH);
        // 8'hFE and 8'hFF are sentinels: both share all-ones upper bits
        rel_ok   = fl.release_valid && (fl.release_tag[TAG_W-1:1] != '1);
        pop      = fl.alloc_req && !fl.restore_state && !zero;
`ifdef FREE_LIST_BYPASS_EN
        byp      = fl.alloc_req && !fl.restore_state && zero && rel_ok;
`else
        byp      = 1'b0;
`endif
        push     = rel_ok && !byp && (!full || pop);
        drop     = rel_ok && full && !pop;
        head_nxt = head_q + (AW+1)'(pop);
        head_d   = fl.restore_state ? ckpt_q[fl.restore_page] : head_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(FIRST_TAG + i);
            for (int i = 0; i < 8; i++) ckpt_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= (AW+1)'(DEPTH);
            addr_q  <= '1;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            valid_q <= pop || byp;
            if (push) begin
                mem_q[tail_q[AW-1:0]] <= fl.release_tag;
                tail_q                <= tail_q + (AW+1)'(1);
            end
            if (fl.save_state && !fl.restore_state) ckpt_q[fl.save_page] <= head_nxt;
            if (pop) addr_q <= mem_q[head_q[AW-1:0]];
            else if (byp) addr_q <= fl.release_tag;
            else if (fl.alloc_req && !fl.restore_state) addr_q <= '1;
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign fl.free_phy_addr = addr_q;
    assign fl.alloc_valid   = valid_q;
    assign fl.empty         = zero;
    assign fl.free_count    = count;
    assign fl.overflow_err  = ovf_q;
endmodule

// File: tb/tb_phys_free_list.sv
// tb_phys_free_list: table-driven vectors plus hand sequences for full/empty/bypass corners.
module tb_phys_free_list;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    phys_free_list_if #(.TAG_W(8), .AW(7)) fl ();
    phys_free_list dut (.clk(clk), .reset(reset), .fl(fl));

    typedef struct {
        logic       a;
        logic       rv;
        logic [7:0] rt;
        logic       sv;
        logic [2:0] sp;
        logic       rs;
        logic [2:0] rp;
        logic       ev;
        logic [7:0] ea;
        logic [7:0] ec;
    } vec_t;

    vec_t vt[24];

    function automatic vec_t mk(logic a, logic rv, logic [7:0] rt, logic sv, logic [2:0] sp,
                                logic rs, logic [2:0] rp, logic ev, logic [7:0] ea, logic [7:0] ec);
        vec_t v;
        v.a = a; v.rv = rv; v.rt = rt; v.sv = sv; v.sp = sp;
        v.rs = rs; v.rp = rp; v.ev = ev; v.ea = ea; v.ec = ec;
        return v;
    endfunction

    task automatic chk(string name, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic step(logic a, logic rv, logic [7:0] rt, logic sv, logic [2:0] sp, logic rs, logic [2:0] rp);
        fl.alloc_req = a; fl.release_valid = rv; fl.release_tag = rt;
        fl.save_state = sv; fl.save_page = sp; fl.restore_state = rs; fl.restore_page = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(string name, logic ev, logic [7:0] ea, logic [7:0] ec);
        chk({name, ".valid"}, int'(fl.alloc_valid), int'(ev));
        chk({name, ".addr"}, int'(fl.free_phy_addr), int'(ea));
        chk({name, ".count"}, int'(fl.free_count), int'(ec));
    endtask

    task automatic do_reset();
        step(0, 0, 8'h00, 0, 0, 0, 0);
        reset = 1'b1;
        #2;
        chk("rst.addr", int'(fl.free_phy_addr), 8'hFF);
        chk("rst.valid", int'(fl.alloc_valid), 0);
        chk("rst.count", int'(fl.free_count), 128);
        chk("rst.empty", int'(fl.empty), 0);
        chk("rst.ovf", int'(fl.overflow_err), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vt[0]  = mk(1,0,8'h00,0,0,0,0, 1,8'd32,8'd127);
        vt[1]  = mk(1,0,8'h00,0,0,0,0, 1,8'd33,8'd126);
        vt[2]  = mk(1,0,8'h00,0,0,0,0, 1,8'd34,8'd125);
        vt[3]  = mk(0,0,8'h00,0,0,0,0, 0,8'd34,8'd125);
        vt[4]  = mk(1,0,8'h00,0,0,0,0, 1,8'd35,8'd124);
        vt[5]  = mk(1,0,8'h00,0,0,0,0, 1,8'd36,8'd123);
        vt[6]  = mk(0,0,8'h00,1,2,0,0, 0,8'd36,8'd123);
        vt[7]  = mk(1,0,8'h00,0,0,0,0, 1,8'd37,8'd122);
        vt[8]  = mk(1,0,8'h00,0,0,0,0, 1,8'd38,8'd121);
        vt[9]  = mk(1,0,8'h00,0,0,0,0, 1,8'd39,8'd120);
        vt[10] = mk(1,0,8'h00,0,0,0,0, 1,8'd40,8'd119);
        vt[11] = mk(0,0,8'h00,0,0,1,2, 0,8'd40,8'd123);
        vt[12] = mk(1,0,8'h00,0,0,0,0, 1,8'd37,8'd122);
        vt[13] = mk(1,0,8'h00,1,5,0,0, 1,8'd38,8'd121);
        vt[14] = mk(1,0,8'h00,0,0,0,0, 1,8'd39,8'd120);
        vt[15] = mk(1,0,8'h00,0,0,1,5, 0,8'd39,8'd121);
        vt[16] = mk(1,0,8'h00,0,0,0,0, 1,8'd39,8'd120);
        vt[17] = mk(0,0,8'h00,1,2,1,5, 0,8'd39,8'd121);
        vt[18] = mk(0,0,8'h00,0,0,1,2, 0,8'd39,8'd123);
        vt[19] = mk(1,0,8'h00,0,0,0,0, 1,8'd37,8'd122);
        vt[20] = mk(0,1,8'h50,0,0,0,0, 0,8'd37,8'd123);
        vt[21] = mk(0,1,8'hFE,0,0,0,0, 0,8'd37,8'd123);
        vt[22] = mk(0,1,8'hFF,0,0,0,0, 0,8'd37,8'd123);
        vt[23] = mk(1,1,8'h51,0,0,0,0, 1,8'd38,8'd123);

        do_reset();
        foreach (vt[i]) begin
            step(vt[i].a, vt[i].rv, vt[i].rt, vt[i].sv, vt[i].sp, vt[i].rs, vt[i].rp);
            expect3($sformatf("vec%0d", i), vt[i].ev, vt[i].ea, vt[i].ec);
        end

        // drain to empty, then bypass / no-bypass corner and alloc+release at count 1
        do_reset();
        step(1, 0, 8'h00, 0, 0, 0, 0);
        expect3("pre", 1, 8'd32, 8'd127);
        step(0, 0, 8'h00, 0, 0, 1, 3);
        expect3("restore_unsaved", 0, 8'd32, 8'd128);
        for (int i = 0; i < 128; i++) begin
            step(1, 0, 8'h00, 0, 0, 0, 0);
            chk($sformatf("drain%0d.addr", i), int'(fl.free_phy_addr), 32 + i);
            chk($sformatf("drain%0d.valid", i), int'(fl.alloc_valid), 1);
        end
        chk("drain.empty", int'(fl.empty), 1);
        chk("drain.count", int'(fl.free_count), 0);
        step(1, 0, 8'h00, 0, 0, 0, 0);
        expect3("alloc_empty", 0, 8'hFF, 8'd0);
        step(1, 1, 8'h09, 0, 0, 0, 0);
`ifdef FREE_LIST_BYPASS_EN
        expect3("bypass", 1, 8'h09, 8'd0);
        step(0, 1, 8'h09, 0, 0, 0, 0);
        expect3("refill", 0, 8'h09, 8'd1);
`else
        expect3("no_bypass", 0, 8'hFF, 8'd1);
`endif
        step(1, 1, 8'h07, 0, 0, 0, 0);
        expect3("cnt1_alloc_rel", 1, 8'h09, 8'd1);
        step(1, 0, 8'h00, 0, 0, 0, 0);
        expect3("cnt1_next", 1, 8'h07, 8'd0);
        chk("cnt1_next.empty", int'(fl.empty), 1);

        // full-list release drop, sticky overflow, sentinel at count 100
        do_reset();
        step(0, 1, 8'h05, 0, 0, 0, 0);
        expect3("full_drop", 0, 8'hFF, 8'd128);
        chk("full_drop.ovf", int'(fl.overflow_err), 1);
        step(0, 0, 8'h00, 0, 0, 0, 0);
        chk("ovf_sticky", int'(fl.overflow_err), 1);
        step(1, 1, 8'h05, 0, 0, 0, 0);
        expect3("full_pop_push", 1, 8'd32, 8'd128);
        for (int i = 0; i < 28; i++) step(1, 0, 8'h00, 0, 0, 0, 0);
        expect3("to100", 1, 8'd60, 8'd100);
        step(0, 1, 8'hFE, 0, 0, 0, 0);
        expect3("sentinel100", 0, 8'd60, 8'd100);
        step(0, 1, 8'h06, 0, 0, 0, 0);
        expect3("rel101", 0, 8'd60, 8'd101);
        chk("ovf_still", int'(fl.overflow_err), 1);

        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
